// File: rtl/mte_frame_if.sv
// ============================================================================
// Module : mte_frame_if
// Brief  : Stream-in / stream-out bundle for the MtE frame receiver.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface mte_frame_if #(
    parameter int N = 8
) ();
    logic [N-1:0] key;
    logic [N-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] out_data;
    logic         out_valid;
    logic         out_last;
    logic         out_ready;
    logic         auth_ok;
    logic         auth_fail;
    logic         frame_err;

    modport slave (
        input  key, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last, auth_ok, auth_fail, frame_err
    );

    modport master (
        output key, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last, auth_ok, auth_fail, frame_err
    );
endinterface

`default_nettype wire

// File: rtl/mte_frame_receiver.sv
// ============================================================================
// Module : mte_frame_receiver
// Brief  : Decrypts MtE frames, verifies the MAC, releases plaintext only on match.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mte_frame_receiver #(
    parameter int MAX_LEN = 16,
    parameter int N       = 8
) (
    input  wire logic   clock,
    input  wire logic   reset_n,
    mte_frame_if.slave  bus
);
    localparam int         c_AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] c_MAX_LEN = 8'(MAX_LEN);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_DATA  = 3'd1;
    localparam logic [2:0] c_MACB  = 3'd2;
    localparam logic [2:0] c_CHECK = 3'd3;
    localparam logic [2:0] c_OUT   = 3'd4;

    logic [2:0]   state_q,  state_d;
    logic [7:0]   len_q,    len_d;
    logic [7:0]   wptr_q,   wptr_d;
    logic [7:0]   rptr_q,   rptr_d;
    logic [N-1:0] key_q,    key_d;
    logic [N-1:0] mac_q,    mac_d;
    logic [N-1:0] rxmac_q,  rxmac_d;
    logic         ferr_q,   ferr_d;
    logic [N-1:0] buf_q [MAX_LEN];

    logic         w_in_fire;
    logic         w_out_fire;
    logic         w_hdr_ok;
    logic         w_match;
    logic [N-1:0] w_plain;

    assign w_in_fire  = bus.in_valid && bus.in_ready;
    assign w_out_fire = bus.out_valid && bus.out_ready;
    assign w_hdr_ok   = (bus.in_data != 8'd0) && (bus.in_data <= c_MAX_LEN);
    assign w_match    = (mac_q == rxmac_q);
    assign w_plain    = bus.in_data ^ key_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= c_IDLE;
            len_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            key_q   <= '0;
            mac_q   <= '0;
            rxmac_q <= '0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            key_q   <= key_d;
            mac_q   <= mac_d;
            rxmac_q <= rxmac_d;
            ferr_q  <= ferr_d;
        end
    end

    // Buffer content is only meaningful behind wptr, so it needs no reset.
    always_ff @(posedge clock) begin
        if (state_q == c_DATA && w_in_fire) begin
            buf_q[wptr_q[c_AW-1:0]] <= w_plain;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        key_d   = key_q;
        mac_d   = mac_q;
        rxmac_d = rxmac_q;
        ferr_d  = 1'b0;
        case (state_q)
            c_IDLE: begin
                if (w_in_fire) begin
                    if (w_hdr_ok) begin
                        len_d   = bus.in_data;
                        key_d   = bus.key;
                        mac_d   = bus.key;
                        wptr_d  = '0;
                        state_d = c_DATA;
                    end else begin
                        ferr_d  = 1'b1;
                    end
                end
            end
            c_DATA: begin
                if (w_in_fire) begin
                    mac_d  = {mac_q[N-2:0], mac_q[N-1]} ^ w_plain;
                    wptr_d = wptr_q + 8'd1;
                    if (wptr_q == len_q - 8'd1) begin
                        state_d = c_MACB;
                    end
                end
            end
            c_MACB: begin
                if (w_in_fire) begin
                    rxmac_d = w_plain;
                    state_d = c_CHECK;
                end
            end
            c_CHECK: begin
                rptr_d  = '0;
                state_d = w_match ? c_OUT : c_IDLE;
            end
            c_OUT: begin
                if (w_out_fire) begin
                    rptr_d = rptr_q + 8'd1;
                    if (bus.out_last) begin
                        state_d = c_IDLE;
                    end
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == c_IDLE) || (state_q == c_DATA) || (state_q == c_MACB);
        bus.out_valid = (state_q == c_OUT);
        bus.out_data  = bus.out_valid ? buf_q[rptr_q[c_AW-1:0]] : '0;
        bus.out_last  = bus.out_valid && (rptr_q == len_q - 8'd1);
        bus.auth_ok   = (state_q == c_CHECK) && w_match;
        bus.auth_fail = (state_q == c_CHECK) && !w_match;
        bus.frame_err = ferr_q;
    end
endmodule

`default_nettype wire

// File: tb/tb_mte_frame_receiver.sv
// ============================================================================
// Module : tb_mte_frame_receiver
// Brief  : Directed plus randomized frames checked against an arithmetic model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mte_frame_receiver;
    localparam int MAX_LEN = 16;
    typedef logic [7:0] q8_t[$];

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   errors  = 0;
    int   checks  = 0;
    int   rdy_mode = 0;

    mte_frame_if #(.N(8)) bus ();

    mte_frame_receiver #(.MAX_LEN(MAX_LEN), .N(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- monitor ----------------
    logic [7:0] outq[$];
    logic       lastq[$];
    int         n_ok, n_fail, n_err;
    int         low_run, last_low_run;
    logic       stall_prev;
    logic [7:0] stall_data;
    logic       stall_last;

    always @(negedge clock) begin
        if (!reset_n) begin
            stall_prev = 1'b0;
            low_run    = 0;
        end else begin
            if (bus.auth_ok)   n_ok++;
            if (bus.auth_fail) n_fail++;
            if (bus.frame_err) n_err++;
            if (bus.auth_ok || bus.auth_fail || bus.frame_err)
                check("flags_onehot", {31'b0, $onehot({bus.auth_ok, bus.auth_fail, bus.frame_err})}, 1);
            if (stall_prev) begin
                check("stall_valid", bus.out_valid, 1);
                check("stall_data", bus.out_data, stall_data);
                check("stall_last", bus.out_last, stall_last);
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            stall_data = bus.out_data;
            stall_last = bus.out_last;
            if (bus.out_valid && bus.out_ready) begin
                outq.push_back(bus.out_data);
                lastq.push_back(bus.out_last);
            end
            if (!bus.in_ready) low_run++;
            else if (low_run != 0) begin
                last_low_run = low_run;
                low_run      = 0;
            end
        end
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            case (rdy_mode)
                1:       bus.out_ready = ~bus.out_ready;
                2:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] ref_mac(input logic [7:0] k, input q8_t p);
        int m = k;
        foreach (p[i]) m = (((m * 2) + (m / 128)) % 256) ^ int'(p[i]);
        return 8'(m);
    endfunction

    function automatic q8_t build(input logic [7:0] k, input q8_t p, input bit corrupt);
        q8_t s;
        logic [7:0] cm;
        s.push_back(8'(p.size()));
        foreach (p[i]) s.push_back(p[i] ^ k);
        cm = ref_mac(k, p) ^ k;
        if (corrupt) cm = cm ^ (8'd1 << $urandom_range(0, 7));
        s.push_back(cm);
        return s;
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    // Called and returns at posedge+1.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        logic r;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                bus.in_valid = 1'b0;
                @(posedge clock);
                #1;
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int t = 0; t < 200; t++) begin
            @(negedge clock);
            r = bus.in_ready;
            @(posedge clock);
            #1;
            if (r) break;
            if (t == 199) check("in_ready_wait", {31'b0, r}, 1);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic clear_mon();
        outq.delete();
        lastq.delete();
        n_ok = 0; n_fail = 0; n_err = 0;
    endtask

    task automatic run_raw(input string tag, input logic [7:0] k, input q8_t s, input bit gaps);
        int         len;
        q8_t        plain;
        bit         ok;
        bit         done;
        len = int'(s[0]);
        for (int i = 0; i < len; i++) plain.push_back(s[1 + i] ^ k);
        ok = (ref_mac(k, plain) == (s[len + 1] ^ k));
        clear_mon();
        bus.key = k;
        foreach (s[i]) begin
            send_byte(s[i], gaps);
            bus.key = 8'($urandom);
        end
        done = 1'b0;
        for (int t = 0; t < 300 && !done; t++) begin
            tick();
            if (n_fail != 0 || n_err != 0) done = 1'b1;
            if (n_ok != 0 && outq.size() >= len && bus.in_ready) done = 1'b1;
        end
        check({tag, "_done"}, {31'b0, done}, 1);
        repeat (2) tick();
        check({tag, "_auth_ok"}, n_ok, ok ? 1 : 0);
        check({tag, "_auth_fail"}, n_fail, ok ? 0 : 1);
        check({tag, "_frame_err"}, n_err, 0);
        check({tag, "_count"}, outq.size(), ok ? len : 0);
        if (ok && outq.size() == len) begin
            for (int i = 0; i < len; i++) begin
                check($sformatf("%s_data%0d", tag, i), outq[i], plain[i]);
                check($sformatf("%s_last%0d", tag, i), lastq[i], (i == len - 1) ? 1 : 0);
            end
        end
        check({tag, "_in_ready"}, bus.in_ready, 1);
        @(posedge clock);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        q8_t s1, s2, p;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.key      = 8'h00;
        s1 = '{8'h02, 8'hB7, 8'h91, 8'h23};
        s2 = '{8'h02, 8'hB7, 8'h91, 8'h24};

        repeat (3) @(posedge clock);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_flags", {29'b0, bus.auth_ok, bus.auth_fail, bus.frame_err}, 0);
        reset_n = 1'b1;
        tick();
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_last", bus.out_last, 0);
        @(posedge clock);
        #1;

        // Basic frame: in_ready low across CHECK and two OUT cycles.
        run_raw("t1", 8'hA5, s1, 1'b0);
        check("t1_in_ready_low", last_low_run, 3);

        run_raw("t2", 8'hA5, s2, 1'b0);
        run_raw("t2_next", 8'hA5, s1, 1'b0);

        // Illegal headers consumed without leaving IDLE.
        clear_mon();
        send_byte(8'h00, 1'b0);
        repeat (2) tick();
        check("t3_err_len0", n_err, 1);
        check("t3_in_ready0", bus.in_ready, 1);
        @(posedge clock);
        #1;
        clear_mon();
        send_byte(8'(MAX_LEN + 1), 1'b0);
        repeat (2) tick();
        check("t3_err_len17", n_err, 1);
        check("t3_no_auth", n_ok + n_fail, 0);
        @(posedge clock);
        #1;
        run_raw("t3_next", 8'h3C, s1, 1'b0);

        rdy_mode = 1;
        run_raw("t4", 8'hA5, s1, 1'b1);

        rdy_mode = 0;
        p.delete();
        for (int i = 0; i < MAX_LEN; i++) p.push_back(8'(i));
        run_raw("t5", 8'h00, build(8'h00, p, 1'b0), 1'b0);
        p.delete();
        p.push_back(8'h5A);
        run_raw("len1", 8'hC3, build(8'hC3, p, 1'b0), 1'b0);

        // Abandon a frame mid-payload with an async reset.
        clear_mon();
        bus.key = 8'hA5;
        send_byte(8'h02, 1'b0);
        send_byte(8'hB7, 1'b0);
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (4) tick();
        check("t6_no_flags", n_ok + n_fail + n_err, 0);
        check("t6_no_out", outq.size(), 0);
        check("t6_in_ready", bus.in_ready, 1);
        @(posedge clock);
        #1;
        run_raw("t6", 8'hA5, s1, 1'b0);

        rdy_mode = 2;
        for (int f = 0; f < 8; f++) begin
            logic [7:0] k;
            p.delete();
            k = 8'($urandom);
            repeat ($urandom_range(1, MAX_LEN)) p.push_back(8'($urandom));
            run_raw($sformatf("rnd%0d", f), k, build(k, p, ($urandom_range(0, 3) == 0)), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
